// File: rtl/branch_pred_pkg.sv
// Shared types and constants for the bimodal branch predictor.
// Optional build macro: BRANCH_PREDICTOR_GSHARE_EN (see branch_predictor.sv).
package branch_pred_pkg;

  // RISC-V major opcodes relevant to control flow
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // 2-bit saturating counter and its named values
  typedef logic [1:0] ctr_t;
  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  // Widest supported table index; slots carry the index zero-extended to this
  localparam int unsigned IDX_MAX = 16;

  // One tracking-pipeline slot
  typedef struct packed {
    logic               valid;
    logic [IDX_MAX-1:0] idx;
    logic               pred;
  } slot_t;

  // Predictor control states
  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } bp_state_t;

  // Conditional-branch decode; jumps are deliberately excluded
  function automatic logic is_cbranch(input logic [31:0] inst);
    return (inst[6:0] == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-value logic for a 2-bit saturating up/down counter.
module bp_sat_ctr
  import branch_pred_pkg::*;
(
  input  ctr_t cur,
  input  logic up,
  output ctr_t nxt
);

  // Step toward the outcome, sticking at the ends instead of wrapping
  always_comb begin
    nxt = cur;
    if (up) begin
      if (cur == ST) nxt = ST;
      else           nxt = cur + 2'b01;
    end else begin
      if (cur == SNT) nxt = SNT;
      else            nxt = cur - 2'b01;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit counters indexed by fetch PC,
// with an ID/EX tracking pipeline so the resolved outcome trains the entry
// that produced the prediction. After reset the table is swept to INIT_CTR.
// Optional build macro: BRANCH_PREDICTOR_GSHARE_EN XORs a global history
// register into the index (gshare).
module branch_predictor
  import branch_pred_pkg::*;
#(
  parameter int unsigned IDX_BITS = 6,
  parameter ctr_t        INIT_CTR = 2'b01
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  input  logic        stall,
  input  logic [1:0]  flush,
  input  logic        ex_taken,
  output logic        prediction,
  output logic        ex_mispredict,
  output logic        ready
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(ENTRIES - 1);

  ctr_t                table_r [ENTRIES];
  bp_state_t           state_r;
  bp_state_t           state_next;
  logic [IDX_BITS-1:0] ptr_r;
  slot_t               id_r;
  slot_t               ex_r;
  slot_t               id_next;
  slot_t               ex_next;

  logic                run;
  logic                init_we;
  logic                is_br;
  logic                upd_en;
  logic [IDX_BITS-1:0] pc_idx;
  logic [IDX_BITS-1:0] idx;
  logic [IDX_BITS-1:0] ex_idx;
  ctr_t                upd_val;

  assign pc_idx = if_pc[IDX_BITS+1:2];
  assign ex_idx = ex_r.idx[IDX_BITS-1:0];
  assign is_br  = is_cbranch(if_inst);
  assign upd_en = run & ex_r.valid & ~stall;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [IDX_BITS-1:0] ghr;

  assign idx = pc_idx ^ ghr;

  // Global history: cleared by reset and the sweep, shifts in resolved outcomes
  always_ff @(posedge clk) begin
    if (rst)          ghr <= '0;
    else if (init_we) ghr <= '0;
    else if (upd_en)  ghr <= {ghr[IDX_BITS-2:0], ex_taken};
    else              ghr <= ghr;
  end
`else
  assign idx = pc_idx;
`endif

  // State register and sweep pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_INIT;
      ptr_r   <= '0;
    end else begin
      state_r <= state_next;
      if (state_r == S_INIT) ptr_r <= ptr_r + IDX_BITS'(1);
      else                   ptr_r <= ptr_r;
    end
  end

  // Next state: leave INIT once the last entry has been written
  always_comb begin
    state_next = state_r;
    case (state_r)
      S_INIT: begin
        if (ptr_r == LAST_IDX) state_next = S_RUN;
        else                   state_next = S_INIT;
      end
      S_RUN:   state_next = S_RUN;
      default: state_next = S_INIT;
    endcase
  end

  // State-decoded controls
  always_comb begin
    run     = 1'b0;
    init_we = 1'b0;
    case (state_r)
      S_INIT:  init_we = 1'b1;
      S_RUN:   run     = 1'b1;
      default: init_we = 1'b1;
    endcase
  end

  assign ready = run;

  // Same-cycle lookup; reads the stored value, no bypass from a pending update
  always_comb begin
    if (run && is_br) prediction = table_r[idx][1];
    else              prediction = 1'b0;
  end

  // Mispredict flag for the branch currently in EX
  always_comb begin
    if (run && ex_r.valid) ex_mispredict = (ex_r.pred != ex_taken);
    else                   ex_mispredict = 1'b0;
  end

  bp_sat_ctr u_sat_ctr (
    .cur (table_r[ex_idx]),
    .up  (ex_taken),
    .nxt (upd_val)
  );

  // Table writes: sweep in INIT, training in RUN (the two are exclusive)
  always_ff @(posedge clk) begin
    if (rst) begin
      table_r[ptr_r] <= table_r[ptr_r];
    end else if (init_we) begin
      table_r[ptr_r] <= INIT_CTR;
    end else if (upd_en) begin
      table_r[ex_idx] <= upd_val;
    end else begin
      table_r[ex_idx] <= table_r[ex_idx];
    end
  end

  // Slot advance (or hold on stall), then flush kills the new slot contents
  always_comb begin
    id_next = id_r;
    ex_next = ex_r;
    if (!stall) begin
      id_next.valid = is_br & run;
      id_next.idx   = IDX_MAX'(idx);
      id_next.pred  = prediction;
      ex_next       = id_r;
    end else begin
      id_next = id_r;
      ex_next = ex_r;
    end
    if (flush[1]) id_next.valid = 1'b0;
    else          id_next.valid = id_next.valid;
    if (flush[0]) ex_next.valid = 1'b0;
    else          ex_next.valid = ex_next.valid;
  end

  // Tracking pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      id_r <= '0;
      ex_r <= '0;
    end else begin
      id_r <= id_next;
      ex_r <= ex_next;
    end
  end

  // Bits of the ports and slot not used by this configuration
  logic unused_bits;
  assign unused_bits = ^{if_inst[31:7], if_pc[31:IDX_BITS+2], if_pc[1:0],
                         ex_r.idx[IDX_MAX-1:IDX_BITS]};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic, all compared against a counter-array reference model.
module tb_branch_predictor;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;
  localparam int         N       = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = 32'd0;
  logic [31:0] if_inst = 32'd0;
  logic        stall = 1'b0;
  logic [1:0]  flush = 2'b00;
  logic        ex_taken = 1'b0;
  logic        prediction;
  logic        ex_mispredict;
  logic        ready;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_ctr [N];
  bit m_known = 1'b0;
  bit m_ready = 1'b0;
  int m_ptr = 0;
  int m_ghr = 0;
  bit m_idv = 1'b0, m_exv = 1'b0;
  int m_ididx = 0, m_exidx = 0;
  bit m_idp = 1'b0, m_exp = 1'b0;

  // Last sampled outputs
  logic s_pred, s_mis, s_ready;

  branch_predictor dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_inst(if_inst), .stall(stall),
    .flush(flush), .ex_taken(ex_taken), .prediction(prediction),
    .ex_mispredict(ex_mispredict), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_index(input logic [31:0] pc);
    int i;
    i = int'(pc[7:2]);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    i = i ^ m_ghr;
`endif
    return i;
  endfunction

  function automatic bit m_pred(input logic [31:0] pc, input logic [31:0] inst);
    if (m_ready && inst[6:0] == OP_BR) return (m_ctr[m_index(pc)] >= 2);
    return 1'b0;
  endfunction

  // Apply one clock edge to the model using the inputs held during the cycle
  task automatic model_edge(input logic r, input logic [31:0] pc, input logic [31:0] inst,
                            input logic st, input logic [1:0] fl, input logic tk);
    bit nv, np;
    int ni;
    if (r) begin
      m_known = 1'b1; m_ready = 1'b0; m_ptr = 0; m_ghr = 0;
      m_idv = 1'b0; m_exv = 1'b0;
      return;
    end
    if (!m_known) return;
    nv = m_ready && (inst[6:0] == OP_BR);
    ni = m_index(pc);
    np = m_pred(pc, inst);
    if (!m_ready) begin
      m_ctr[m_ptr] = 1;
      m_ptr++;
      m_ghr = 0;
      if (m_ptr == N) m_ready = 1'b1;
    end else if (!st && m_exv) begin
      if (tk) m_ctr[m_exidx] = (m_ctr[m_exidx] == 3) ? 3 : m_ctr[m_exidx] + 1;
      else    m_ctr[m_exidx] = (m_ctr[m_exidx] == 0) ? 0 : m_ctr[m_exidx] - 1;
      m_ghr = ((m_ghr << 1) | int'(tk)) % N;
    end
    if (!st) begin
      m_exv = m_idv; m_exidx = m_ididx; m_exp = m_idp;
      m_idv = nv;    m_ididx = ni;      m_idp = np;
    end
    if (fl[1]) m_idv = 1'b0;
    if (fl[0]) m_exv = 1'b0;
  endtask

  // One cycle: drive, sample and compare mid-cycle, then advance the model
  task automatic step(input logic r, input logic [31:0] pc, input logic [6:0] opc,
                      input logic st, input logic [1:0] fl, input logic tk);
    logic [31:0] rnd, inst;
    rnd = $urandom();
    inst = {rnd[31:7], opc};
    @(negedge clk);
    rst = r; if_pc = pc; if_inst = inst; stall = st; flush = fl; ex_taken = tk;
    #1;
    s_pred = prediction; s_mis = ex_mispredict; s_ready = ready;
    if (m_known) begin
      check("ready", {31'd0, ready}, {31'd0, m_ready});
      check("prediction", {31'd0, prediction}, {31'd0, m_pred(pc, inst)});
      check("ex_mispredict", {31'd0, ex_mispredict},
            {31'd0, m_ready && m_exv && (m_exp != tk)});
    end
    @(posedge clk);
    model_edge(r, pc, inst, st, fl, tk);
  endtask

  task automatic idle(input logic tk);
    step(1'b0, 32'h0, OP_ALU, 1'b0, 2'b00, tk);
  endtask

  // Reset, then count the cycles until ready rises
  task automatic do_reset(input string tag);
    int n;
    step(1'b1, 32'h0, OP_ALU, 1'b0, 2'b00, 1'b0);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      idle(1'b0);
      if (s_ready) break;
      n++;
    end
    check(tag, n, 64);
  endtask

  // Fetch a branch and resolve it two cycles later with the given outcome
  task automatic train(input logic [31:0] pc, input logic tk);
    step(1'b0, pc, OP_BR, 1'b0, 2'b00, 1'b0);
    idle(1'b0);
    idle(tk);
  endtask

  initial begin
    logic [31:0] pcs [4];
    logic [6:0]  ops [4];
    pcs[0] = 32'h40; pcs[1] = 32'h80; pcs[2] = 32'h144; pcs[3] = 32'h1C;
    ops[0] = OP_BR;  ops[1] = OP_JAL; ops[2] = OP_JALR; ops[3] = OP_ALU;

    step(1'b1, 32'h0, OP_ALU, 1'b0, 2'b00, 1'b0);
    do_reset("init_len");

    // Entry 16 starts weakly not-taken; first resolution is a mispredict
    step(1'b0, 32'h40, OP_BR, 1'b0, 2'b00, 1'b0);
    check("pred_wnt", {31'd0, s_pred}, 32'd0);
    idle(1'b0);
    idle(1'b1);
    check("mis_first", {31'd0, s_mis}, 32'd1);
    train(32'h40, 1'b1);                          // 10 -> 11
    step(1'b0, 32'h40, OP_BR, 1'b0, 2'b00, 1'b0);
    check("pred_st", {31'd0, s_pred}, 32'd1);
    idle(1'b0);
    idle(1'b1);                                   // saturates at 11
    train(32'h40, 1'b0);                          // 11 -> 10
    step(1'b0, 32'h40, OP_BR, 1'b0, 2'b00, 1'b0);
    check("pred_wt", {31'd0, s_pred}, 32'd1);
    idle(1'b0);
    idle(1'b1);                                   // back to 11

    // Mispredict with full flush, then EX must be empty
    step(1'b0, 32'h80, OP_BR, 1'b0, 2'b00, 1'b0);
    step(1'b0, 32'h80, OP_BR, 1'b0, 2'b00, 1'b0);
    step(1'b0, 32'h0, OP_ALU, 1'b0, 2'b11, 1'b1);
    check("mis_flush", {31'd0, s_mis}, 32'd1);
    idle(1'b1);
    check("flushed_ex", {31'd0, s_mis}, 32'd0);

    // Stall three cycles with a branch in EX; one update only
    train(32'h0C0, 1'b0);
    step(1'b0, 32'h0C0, OP_BR, 1'b0, 2'b00, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, OP_ALU, 1'b1, 2'b00, 1'b1);
    idle(1'b1);
    step(1'b0, 32'h0C0, OP_BR, 1'b0, 2'b00, 1'b0);
    check("stall_one_upd", {31'd0, s_pred}, 32'd0);

    // Non-branch and jump are never tracked
    step(1'b0, 32'h100, OP_ALU, 1'b0, 2'b00, 1'b1);
    check("alu_pred", {31'd0, s_pred}, 32'd0);
    step(1'b0, 32'h104, OP_JAL, 1'b0, 2'b00, 1'b1);
    check("jal_pred", {31'd0, s_pred}, 32'd0);
    idle(1'b1);
    idle(1'b1);
    check("jal_not_tracked", {31'd0, s_mis}, 32'd0);

    // Reset in RUN restores entry 16 to weakly not-taken
    do_reset("reinit_len");
    step(1'b0, 32'h40, OP_BR, 1'b0, 2'b00, 1'b0);
    check("pred_after_reset", {31'd0, s_pred}, 32'd0);

    // Randomized traffic over a few colliding PCs
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      logic [6:0]  op;
      logic        st, r;
      logic [1:0]  fl;
      pc = ($urandom_range(0, 3) == 0) ? {$urandom()} : pcs[$urandom_range(0, 3)];
      op = ($urandom_range(0, 2) != 0) ? OP_BR : ops[$urandom_range(0, 3)];
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r  = ($urandom_range(0, 999) == 0);
      step(r, pc, op, st, fl, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
